// File: rtl/alu16_nibble_seq.sv
// alu16_nibble_seq -- multi-cycle add/subtract unit built around one reused
// 4-bit carry-lookahead slice (adder4).
//
// A request (op, a, b, cin) is accepted in IDLE. Operand B is stored
// pre-inverted for subtract ops, so every op becomes A + B' + c0. The slice
// then processes one nibble per cycle, LSB first. The carry between nibbles
// is held in a register.
//
// Ports of adder4:
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out
//
// Ports of alu16_nibble_seq (W = 4*NIBBLES):
//   clk, reset           : clock; synchronous active-high reset
//   in_valid, in_ready   : request handshake. in_ready is a registered
//                          copy of "state is IDLE".
//   op[1:0]              : 00 ADD, 01 SUB, 10 ADC, 11 SBB
//   a, b [W-1:0], cin    : operands and carry in
//   out_valid, out_ready : response handshake
//   result [W-1:0]       : sum or difference
//   cout                 : carry out (for SUB/SBB, 1 = no borrow)
//   ovf                  : signed overflow
//   zero                 : result equals zero

module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [3:0] c_s;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g_s    = a & b;
        p_s    = a ^ b;
        c_s[0] = ci;
        c_s[1] = g_s[0] | (p_s[0] & ci);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & ci);
        co     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);
        s      = p_s ^ c_s;
    end
endmodule

module alu16_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic                 zero
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    bp_r;
    logic            carry_r;
    logic [KW-1:0]   k_r;
    logic [W-1:0]    result_r;
    logic            cout_r;
    logic            ovf_r;
    logic            zero_r;
    logic            in_ready_r;
    logic            out_valid_r;

    logic            carry_init_s;
    logic [3:0]      slice_a_s;
    logic [3:0]      slice_b_s;
    logic [3:0]      slice_sum_s;
    logic            slice_co_s;
    logic [W-1:0]    result_nxt_s;
    logic            zero_s;
    logic            ovf_s;
    logic            k_last_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_nxt_s = ST_RUN;
                else          state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (k_last_s) state_nxt_s = ST_DONE;
                else          state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Initial carry: SUB forms two's complement; ADC/SBB feed cin straight in
    // (SBB then yields A - B - ~cin, since B is stored inverted).
    always_comb begin
        carry_init_s = 1'b0;
        case (op)
            2'b00:   carry_init_s = 1'b0;
            2'b01:   carry_init_s = 1'b1;
            2'b10:   carry_init_s = cin;
            2'b11:   carry_init_s = cin;
            default: carry_init_s = 1'b0;
        endcase
    end

    // Select the current nibble of each registered operand.
    always_comb begin
        k_last_s  = (k_r == K_LAST);
        slice_a_s = a_r[{k_r, 2'b00} +: 4];
        slice_b_s = bp_r[{k_r, 2'b00} +: 4];
    end

    adder4 u_slice (
        .a  (slice_a_s),
        .b  (slice_b_s),
        .ci (carry_r),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // Merge the slice sum into the result. The zero and overflow flags
    // are taken from the merged value; they are only latched on the
    // MSB nibble.
    always_comb begin
        result_nxt_s                       = result_r;
        result_nxt_s[{k_r, 2'b00} +: 4]    = slice_sum_s;
        zero_s = (result_nxt_s == {W{1'b0}});
        ovf_s  = (a_r[W-1] == bp_r[W-1]) & (slice_sum_s[3] != a_r[W-1]);
    end

    // Datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r         <= {W{1'b0}};
            bp_r        <= {W{1'b0}};
            carry_r     <= 1'b0;
            k_r         <= {KW{1'b0}};
            result_r    <= {W{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        bp_r    <= op[0] ? ~b : b;
                        k_r     <= {KW{1'b0}};
                        carry_r <= carry_init_s;
                    end
                end
                ST_RUN: begin
                    result_r <= result_nxt_s;
                    carry_r  <= slice_co_s;
                    if (k_last_s) begin
                        cout_r <= slice_co_s;
                        ovf_r  <= ovf_s;
                        zero_r <= zero_s;
                    end else begin
                        k_r <= k_r + K_ONE;
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;
endmodule

// File: tb/tb_alu16_nibble_seq.sv
// Self-checking bench for alu16_nibble_seq (NIBBLES = 4).
// A negedge monitor holds a queue of pending results. It computes each
// result with plain 17-bit and signed integer arithmetic, and checks the
// handshake and the outputs on every cycle. Directed tasks add
// hand-computed literal expectations.

module tb_alu16_nibble_seq;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        zr;
        int          due;
    } exp_t;

    exp_t q[$];
    bit   started = 1'b0;
    bit   chk_zero = 1'b0;

    alu16_nibble_seq #(.NIBBLES(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Arithmetic reference: A op B written as ordinary integer math.
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] x,
                                   input logic [15:0] y, input logic c, input int due);
        exp_t e;
        int   ua, ub, us, sa, sb, ss, ci;
        if (o == 2'b00)      ci = 0;
        else if (o == 2'b01) ci = 1;
        else                 ci = c ? 1 : 0;
        ua = int'(x);
        ub = o[0] ? (65535 - int'(y)) : int'(y);
        us = ua + ub + ci;
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        ss = sa + sb + ci;
        e.res = 16'(us % 65536);
        e.co  = (us >= 65536);
        e.ov  = (ss > 32767) || (ss < -32768);
        e.zr  = ((us % 65536) == 0);
        e.due = due;
        return e;
    endfunction

    // Per-cycle comparison against the queued model results.
    always @(negedge clk) begin : monitor
        bit exp_v;
        bit acc;
        exp_v = (q.size() > 0) && (cyc >= q[0].due);
        if (started) begin
            if (chk_zero) begin
                check("rst_result", result, 16'h0000);
                check("rst_cout", cout, 1'b0);
                check("rst_ovf", ovf, 1'b0);
                check("rst_zero", zero, 1'b0);
                chk_zero = 1'b0;
            end
            check("mon_in_ready", in_ready, q.size() == 0);
            check("mon_out_valid", out_valid, exp_v);
            if (exp_v && out_valid) begin
                check("mon_result", result, q[0].res);
                check("mon_cout", cout, q[0].co);
                check("mon_ovf", ovf, q[0].ov);
                check("mon_zero", zero, q[0].zr);
            end
        end
        if (reset) begin
            q.delete();
            chk_zero = 1'b1;
            started  = 1'b1;
        end else if (started) begin
            acc = in_valid && (q.size() == 0);
            if (exp_v && out_ready) void'(q.pop_front());
            if (acc) q.push_back(model(op, a, b, cin, cyc + 1 + N));
        end
    end

    // Present a request and wait until it is taken; returns at accept edge + #1.
    task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic c, output int acc_cyc);
        bit got;
        got = 1'b0;
        op = o; a = x; b = y; cin = c; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("issue_wait", got, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    // Wait for out_valid and compare against hand-computed literals.
    task automatic expect_res(input string name, input logic [15:0] r, input logic co,
                              input logic ov, input logic zr, input int acc_cyc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_valid"}, got, 1'b1);
        check({name, "_latency"}, cyc - acc_cyc, 4);
        check({name, "_result"}, result, r);
        check({name, "_cout"}, cout, co);
        check({name, "_ovf"}, ovf, ov);
        check({name, "_zero"}, zero, zr);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc;
        int last;
        int n;
        logic [15:0] held;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, 16'h0000);
        @(posedge clk); #1;

        issue(2'b00, 16'h1234, 16'h4321, 1'b0, acc);
        expect_res("add_basic", 16'h5555, 1'b0, 1'b0, 1'b0, acc);
        @(posedge clk); #1;
        issue(2'b00, 16'hFFFF, 16'h0001, 1'b0, acc);
        expect_res("add_ripple", 16'h0000, 1'b1, 1'b0, 1'b1, acc);
        @(posedge clk); #1;
        issue(2'b01, 16'h8000, 16'h0001, 1'b0, acc);
        expect_res("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0, acc);
        @(posedge clk); #1;
        issue(2'b00, 16'h7FFF, 16'h0001, 1'b0, acc);
        expect_res("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, acc);
        @(posedge clk); #1;
        issue(2'b01, 16'h0003, 16'h0005, 1'b0, acc);
        expect_res("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b0, acc);

        // 32-bit chain: low word, then high word with backpressure.
        @(posedge clk); #1;
        issue(2'b00, 16'hFFFF, 16'h0001, 1'b0, acc);
        expect_res("chain_lo", 16'h0000, 1'b1, 1'b0, 1'b1, acc);
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(2'b10, 16'h0001, 16'h0000, 1'b1, acc);
        expect_res("chain_hi", 16'h0002, 1'b0, 1'b0, 1'b0, acc);
        held = result;
        @(posedge clk); #1;
        op = 2'b00; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_result_stable", result, held);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_no_extra_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // Reset two cycles into RUN.
        issue(2'b00, 16'hAAAA, 16'h5555, 1'b0, acc);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_result", result, 16'h0000);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        issue(2'b00, 16'h0001, 16'h0001, 1'b0, acc);
        expect_res("after_abort", 16'h0002, 1'b0, 1'b0, 1'b0, acc);

        // Back-to-back SBB with both handshakes held high.
        @(posedge clk); #1;
        op = 2'b11; a = 16'h0010; b = 16'h0001; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        last = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                check("b2b_result", result, 16'h000E);
                check("b2b_cout", cout, 1'b1);
                if (n > 0) check("b2b_period", cyc - last, 6);
                last = cyc;
                n++;
            end
        end
        check("b2b_count", n, 3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu16_nibble_seq.md
# alu16_nibble_seq

Multi-cycle 16-bit add/subtract unit that reuses one 4-bit carry-lookahead adder slice (`adder4`) over successive cycles. It presents a valid/ready request and response interface, sequences the slice nibble by nibble through a registered carry, and returns the result with its flags. It sits between the ALU operand registers and the result writeback stage. It trades latency for area against a full-width lookahead adder.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit slices per operation. Datapath width W = 4·NIBBLES. Legal range is 1..8.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: request present.
- `in_ready`, output, 1: unit can accept a request.
- `op`, input, 2: operation select.
  - 00 ADD: A+B.
  - 01 SUB: A−B.
  - 10 ADC: A+B+cin.
  - 11 SBB: A−B−(~cin).
- `a`, input, W: first operand.
- `b`, input, W: second operand.
- `cin`, input, 1: carry in, used by ADC and SBB only.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer accepts the result.
- `result`, output, W: sum or difference.
- `cout`, output, 1: carry out of the MSB. For SUB and SBB, 1 means no borrow.
- `ovf`, output, 1: signed overflow.
- `zero`, output, 1: result == 0.

## Operation
The block has three states: IDLE, RUN and DONE.

**IDLE**
- `in_ready` = 1.
- When `in_valid` is high, the block accepts the request on the next edge. It latches `a`, latches B' = (op[0] ? ~b : b), sets the nibble index k = 0, and goes to RUN.
- The initial carry register is loaded as follows:
  - ADD: 0.
  - SUB: 1.
  - ADC: `cin`.
  - SBB: `cin`.
  - This gives A + ~B + cin, so SBB computes A−B−~cin.

**RUN**
- `in_ready` = 0. `a`, `b`, `op` and `cin` are ignored.
- Each cycle, the single `adder4` instance adds nibble k of A and nibble k of B' with the carry register as its carry in.
- On the edge:
  - The sum is written into `result[4k+3:4k]`.
  - The slice carry out is written to the carry register.
  - k increments.
- When k = NIBBLES−1, the following happen on that edge:
  - The state goes to DONE.
  - `cout` is set to the slice carry out.
  - `ovf` = (A[W−1] == B'[W−1]) & (S[W−1] != A[W−1]).
  - `zero` is computed from the complete result.

**DONE**
- `out_valid` = 1.
- `result`, `cout`, `ovf` and `zero` are held stable until the handshake completes.
- When `out_ready` is high on an edge, the state goes to IDLE and `out_valid` falls.
- No new request is accepted in DONE.

**General rules**
- Outputs from a previous operation remain visible after DONE→IDLE. They change only as RUN overwrites them.
- The consumer samples outputs only while `out_valid` = 1.
- k is a counter of width ceil(log2(NIBBLES)) minimum. It wraps only through the reset-to-0 on request acceptance, never by overflow.
- NIBBLES = 1: RUN lasts exactly one cycle.

## Timing
- **Reset values:**
  - State is IDLE.
  - `in_ready` = 1 from the first cycle after reset.
  - `out_valid` = 0.
  - `result` = 0.
  - `cout` = 0, `ovf` = 0, `zero` = 0.
  - k = 0 and the carry register = 0.
- **Latency:** request accepted at edge E0 → `out_valid` high after edge E0+NIBBLES. This is 4 cycles at the default.
- **Minimum issue period:** NIBBLES+2 cycles (accept, NIBBLES RUN cycles, one DONE cycle with `out_ready` = 1). The next `in_ready` is high the cycle after DONE exits.
- **Backpressure:** DONE persists indefinitely while `out_ready` = 0, with outputs frozen.
- **Simultaneous events:**
  - `reset` overrides all other inputs in the same cycle.
  - `in_valid` in DONE is ignored. The requester must hold it until `in_ready`.
- **Reset mid-RUN or mid-DONE:**
  - The operation is discarded.
  - All outputs return to reset values on that edge.
  - No `out_valid` is produced for the aborted request.
- **Slice path:** the only combinational path through `adder4` is from the registered operands to the result and carry registers. No input-to-output combinational path exists except `in_ready`, which is derived from state only.

## Test plan
- **Reset then ADD:** reset, then ADD 0x1234 + 0x4321.
  - Required: `out_valid` exactly 4 cycles after acceptance, `result` = 0x5555, cout=0, ovf=0, zero=0.
- **Carry ripple:** ADD 0xFFFF + 0x0001.
  - Required: `result` = 0x0000, cout=1, zero=1, ovf=0. This checks the carry propagating across all nibble boundaries.
- **Signed overflow:**
  - SUB 0x8000 − 0x0001. Required: 0x7FFF, cout=1, ovf=1.
  - ADD 0x7FFF + 0x0001. Required: 0x8000, ovf=1, cout=0.
  - SUB 0x0003 − 0x0005. Required: 0xFFFE, cout=0, ovf=0.
- **Chained 32-bit add with backpressure:** ADC chain computing 0x0001_FFFF + 0x0000_0001.
  - Low word: ADD returns 0x0000 with cout=1.
  - High word: ADC with cin=1 returns 0x0002.
  - Hold `out_ready`=0 for 5 cycles in DONE. Required: outputs stable, `in_ready`=0 throughout, and `in_valid` asserted during DONE is not accepted.
- **Reset mid-RUN:** assert `reset` during RUN, 2 cycles after accepting ADD 0xAAAA + 0x5555.
  - Required: outputs all 0 on the next edge, no `out_valid`.
  - Required: a following ADD 0x0001 + 0x0001 returns 0x0002 with correct latency.
- **Back-to-back throughput:** with `out_ready` held 1, `in_valid` held 1 and SBB operations A=0x0010, B=0x0001, cin=0 repeated.
  - Required: result 0x000E each time, one result every 6 cycles.
